uart_seg7_display: RTL

Parametrised UART-to-seven-segment display controller: receives 8-bit command bytes over a serial line and drives `DIGITS_NUM` seven-segment digits. It generalises the fixed four-digit display path with:
- configurable digit count
- optional parity checking
- selectable segment polarity
- a clear-all command
- per-digit valid flags
- error reporting

It sits directly between the board UART pin and the HEX display pins.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/uart_rx_core.sv | 157 +++++++++++++++
 rtl/uart_seg7_display.sv | 87 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the UART-driven seven-segment display.
// Provides the active-high hex glyph table, the blank pattern, the
// clear-all command byte, the receiver state encoding and a helper that
// maps an active-high glyph onto the pin polarity of the board.
package seg7_pkg;

  // Active-high glyphs for hex digits 0..F, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [7:0] CMD_CLEAR = 8'hF0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Convert an active-high segment pattern into the pin polarity
  function automatic logic [6:0] seg_pin(input logic [6:0] seg, input logic active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 / 8E1 UART receiver.
// Ports:
//   clk, resetn      - system clock, async active-low reset
//   uart_rx          - raw serial line (idle high, asynchronous)
//   rx_data[7:0]     - last received byte, valid while rx_valid is high
//   rx_valid         - one-cycle pulse for an accepted byte
//   frame_err        - one-cycle pulse when the stop bit is low
//   parity_err       - one-cycle pulse on even-parity mismatch
module uart_rx_core
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50,
  parameter int unsigned BIT_RATE  = 115200,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned BIT_PERIOD  = (CLK_FREQ * 1000000 + BIT_RATE / 2) / BIT_RATE;
  localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
  localparam int unsigned CNT_W       = $clog2(BIT_PERIOD);

  // Synchroniser and previous-sample flops reset to 0 so that a frame can
  // only start after the line has actually been seen high.
  logic            meta_q, sync_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bad_q, par_bad_d;
  logic            valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
  logic            tick_s, half_s;

  assign tick_s = (cnt_q == CNT_W'(BIT_PERIOD - 1));
  assign half_s = (cnt_q == CNT_W'(HALF_PERIOD - 1));

  // Line synchroniser and receiver state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      prev_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      par_bad_q <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      meta_q    <= uart_rx;
      sync_q    <= meta_q;
      prev_q    <= sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state and result logic of the receiver
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
        // Falling edge only: after a low stop bit the line must rise first
        if (prev_q && !sync_q) begin
          state_d   = START;
          par_bad_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (half_s) begin
          cnt_d = '0;
          if (!sync_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (tick_s) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (tick_s) begin
          cnt_d     = '0;
          par_bad_d = (sync_q != ^shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (tick_s) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!sync_q) begin
            ferr_d = 1'b1;
          end else if (par_bad_q) begin
            perr_d = 1'b1;
          end else begin
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = 3'd0;
      end
    endcase
  end

  assign rx_data    = shift_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;

endmodule

// File: rtl/uart_seg7_display.sv
// UART command receiver driving DIGITS_NUM seven-segment digits.
// Each accepted byte {idx,val} writes hex glyph val to digit idx; byte
// 8'hF0 blanks every digit and clears every valid flag.
// Ports:
//   clk, resetn      - system clock, async active-low reset
//   uart_rx          - serial line from the board pin
//   leds_data[n]     - segments {g,f,e,d,c,b,a} in pin polarity
//   led_data_valid   - per-digit written-since-clear flag
//   frame_err        - one-cycle pulse, stop bit sampled low
//   parity_err       - one-cycle pulse, parity mismatch
module uart_seg7_display
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50,
  parameter int unsigned BIT_RATE       = 115200,
  parameter int unsigned DIGITS_NUM     = 4,
  parameter int unsigned PARITY_EN      = 0,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  uart_rx,
  output logic [6:0]            leds_data [DIGITS_NUM],
  output logic [DIGITS_NUM-1:0] led_data_valid,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam logic ACT_LOW = (SEG_ACTIVE_LOW != 0);

  logic [7:0]            rx_data_s;
  logic                  rx_valid_s;
  logic [6:0]            leds_q [DIGITS_NUM];
  logic [6:0]            leds_d [DIGITS_NUM];
  logic [DIGITS_NUM-1:0] valid_q, valid_d;

  uart_rx_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BIT_RATE  (BIT_RATE),
    .PARITY_EN (PARITY_EN)
  ) u_rx (
    .clk        (clk),
    .resetn     (resetn),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data_s),
    .rx_valid   (rx_valid_s),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // Command decode; digit registers hold pin-polarity patterns
  always_comb begin
    leds_d  = leds_q;
    valid_d = valid_q;
    for (int i = 0; i < DIGITS_NUM; i++) begin
      if (rx_valid_s && (rx_data_s == CMD_CLEAR)) begin
        leds_d[i]  = seg_pin(SEG_BLANK, ACT_LOW);
        valid_d[i] = 1'b0;
      end else if (rx_valid_s && (rx_data_s[7:4] == 4'(i))) begin
        leds_d[i]  = seg_pin(SEG_GLYPH[rx_data_s[3:0]], ACT_LOW);
        valid_d[i] = 1'b1;
      end else begin
        leds_d[i]  = leds_q[i];
        valid_d[i] = valid_q[i];
      end
    end
  end

  // Digit and valid-flag registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DIGITS_NUM; i++) begin
        leds_q[i] <= seg_pin(SEG_BLANK, ACT_LOW);
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DIGITS_NUM; i++) begin
        leds_q[i] <= leds_d[i];
      end
      valid_q <= valid_d;
    end
  end

  assign leds_data      = leds_q;
  assign led_data_valid = valid_q;

endmodule
